// File: rtl/fabric_bist_checker.sv
// On-chip random-stimulus BIST: drives an eFPGA fabric and its reference model from one
// LFSR, compares their outputs after a settle window and counts rising per-output mismatches.
module fabric_bist_checker #(
    parameter int          IN_W    = 9,
    parameter int          OUT_W   = 5,
    parameter int          NUM_VEC = 10,
    parameter int          SETTLE  = 1,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter int          ERR_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [IN_W-1:0]            stim_o,
    input  logic [OUT_W-1:0]           dut_out_i,
    input  logic [OUT_W-1:0]           ref_out_i,
    input  logic [OUT_W-1:0]           ref_valid_i,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_count,
    output logic [$clog2(NUM_VEC):0]   first_err_vec,
    output logic [OUT_W-1:0]           first_err_bits,
    output logic [OUT_W-1:0]           mis_flag_o
);

    localparam int          VEC_W    = $clog2(NUM_VEC) + 1;
    localparam int          SC_W     = $clog2(SETTLE + 1);
    localparam int          POP_W    = 6;
    localparam int          SUM_W    = ERR_W + POP_W;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_TAP = 32'h8020_0003;
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         lfsr_q;
    logic [31:0]         lfsr_nxt;
    logic [IN_W-1:0]     stim_q;
    logic [SC_W-1:0]     settle_q;
    logic [VEC_W-1:0]    vec_q;
    logic [ERR_W-1:0]    err_q;
    logic [ERR_W-1:0]    err_d;
    logic [VEC_W-1:0]    fev_q;
    logic [OUT_W-1:0]    feb_q;
    logic [OUT_W-1:0]    mis_q;
    logic                have_err_q;
    logic                run_start;
    logic                launch;
    logic                compare;
    logic [OUT_W-1:0]    mis_now;
    logic [POP_W-1:0]    rise_cnt;
    logic [SUM_W-1:0]    err_sum;

    function automatic logic [POP_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + {{(POP_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign launch    = (state_q == S_APPLY);
    assign compare   = (state_q == S_WAIT) && (settle_q == '0);

    assign lfsr_nxt  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAP) : (lfsr_q >> 1);

    // Only flags that rise on this compare are counted, so a stuck output counts once.
    assign mis_now   = (dut_out_i ^ ref_out_i) & ref_valid_i;
    assign rise_cnt  = popcount(mis_now & ~mis_q);
    assign err_sum   = {{POP_W{1'b0}}, err_q} + {{ERR_W{1'b0}}, rise_cnt};
    assign err_d     = (err_sum[SUM_W-1:ERR_W] != '0) ? ERR_MAX : err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_APPLY;
            S_APPLY:        state_d = S_WAIT;
            S_WAIT: begin
                if (settle_q == '0) begin
                    state_d = (vec_q == LAST_VEC) ? S_DONE : S_APPLY;
                end
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_APPLY) || (state_q == S_WAIT);
        done = (state_q == S_DONE);
        pass = (state_q == S_DONE) && (err_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q     <= SEED_EFF;
            stim_q     <= '0;
            settle_q   <= '0;
            vec_q      <= '0;
            err_q      <= '0;
            fev_q      <= '0;
            feb_q      <= '0;
            mis_q      <= '0;
            have_err_q <= 1'b0;
        end else begin
            if (run_start) begin
                lfsr_q     <= SEED_EFF;
                vec_q      <= '0;
                err_q      <= '0;
                fev_q      <= '0;
                feb_q      <= '0;
                mis_q      <= '0;
                have_err_q <= 1'b0;
            end
            if (launch) begin
                stim_q   <= lfsr_nxt[IN_W-1:0];
                lfsr_q   <= lfsr_nxt;
                settle_q <= SETTLE_LOAD;
            end
            if ((state_q == S_WAIT) && (settle_q != '0)) begin
                settle_q <= settle_q - SC_W'(1);
            end
            if (compare) begin
                mis_q <= mis_now;
                err_q <= err_d;
                if ((mis_now != '0) && !have_err_q) begin
                    have_err_q <= 1'b1;
                    fev_q      <= vec_q;
                    feb_q      <= mis_now;
                end
                if (vec_q != LAST_VEC) begin
                    vec_q <= vec_q + VEC_W'(1);
                end
            end
        end
    end

    assign stim_o         = stim_q;
    assign err_count      = err_q;
    assign first_err_vec  = fev_q;
    assign first_err_bits = feb_q;
    assign mis_flag_o     = mis_q;

endmodule

// File: doc/fabric_bist_checker.md
Name: fabric_bist_checker

Overview:
- Synthesizable on-chip counterpart of the random formal-verification bench for a mapped eFPGA design.
- Generates pseudo-random stimulus for the fabric inputs and, in parallel, for an embedded reference copy of the benchmark.
- Compares the fabric outputs against the reference outputs after a settle window and counts mismatches per output.
- Sits beside the fabric top and is controlled by a start/done handshake from the test controller.

Parameters:
- IN_W, 9: stimulus width. Range 1..32.
- OUT_W, 5: number of compared outputs. Range 1..32.
- NUM_VEC, 10: vectors per run. Must be at least 1.
- SETTLE, 1: cycles from stimulus launch to compare. Must be at least 1.
- SEED, 32'h00000001: LFSR seed. A value of 0 is replaced by 1.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launches a run when sampled high in IDLE or DONE.
- stim_o  out  IN_W  registered stimulus, driven to both fabric and reference.
- dut_out_i  in  OUT_W  fabric outputs.
- ref_out_i  in  OUT_W  reference outputs.
- ref_valid_i  in  OUT_W  per-bit compare enable; 0 means don't-care.
- busy  out  1  high while a run is active.
- done  out  1  high from run end until next start.
- pass  out  1  equals (err_count==0) while done.
- err_count  out  ERR_W  saturating count of mismatch rising events.
- first_err_vec  out  clog2(NUM_VEC)+1  index of the first vector with a mismatch.
- first_err_bits  out  OUT_W  mismatch bits at that vector.
- mis_flag_o  out  OUT_W  registered per-output mismatch flags.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0. LFSR=SEED (or 1 if SEED=0). vec_cnt=0, settle_cnt=0.
- LFSR: 32-bit Galois, right shift. If lsb==1, next=(lfsr>>1)^32'h80200003; else next=lfsr>>1. Advances exactly once per vector.
- FSM states: IDLE, APPLY, WAIT, DONE.
- IDLE, start=1: clear err_count, mis_flag_o, first_err_*, done, pass, vec_cnt; reload LFSR from SEED; go to APPLY; busy=1.
- APPLY (1 cycle): at the exiting edge, stim_o<=lfsr[IN_W-1:0], LFSR advances, settle_cnt<=SETTLE-1, go to WAIT.
- WAIT: decrement settle_cnt each cycle. The edge where settle_cnt==0 is the compare edge:
  - m = (dut_out_i ^ ref_out_i) & ref_valid_i
  - mis_flag_o <= m
  - err_count += popcount(m & ~mis_flag_o), i.e. rising flags only. A persistent mismatch on one output counts once until it clears. The add saturates at 2^ERR_W-1.
  - If m!=0 and no earlier error: first_err_vec<=vec_cnt, first_err_bits<=m.
  - If vec_cnt==NUM_VEC-1, go to DONE; otherwise vec_cnt++ and go to APPLY.
- Timing: vector period = 1+SETTLE cycles. done rises at edge NUM_VEC*(1+SETTLE) counting the start-sampling edge as edge 0.
- DONE: busy=0, done=1, pass=(err_count==0). stim_o holds its last value. start=1 restarts exactly as from IDLE, so the stimulus sequence is reproducible.
- start while busy: ignored.
- rst_n low at any point, including mid-run: immediate return to reset values. No partial result is retained.
- Simultaneous compare with the last vector and saturation: the saturated value is what is reported in DONE.

Test Plan:
- Reset: rst_n=0 with start toggling -> all outputs 0, busy=0. After release, hold start=0 -> state stays IDLE.
- SEED=1, IN_W=9, start pulse -> stim_o=9'h003 after edge 1 (LFSR=32'h80200003).
- Clean run: dut_out_i tied to ref_out_i, ref_valid_i='1, NUM_VEC=10, SETTLE=1 -> busy high for edges 1..20, done=1 after edge 20, pass=1, err_count=0.
- Persistent fault: dut_out_i[2] = ~ref_out_i[2] every vector -> err_count=1, first_err_vec=0, first_err_bits=5'b00100, mis_flag_o=5'b00100 at done, pass=0.
- Toggling fault: bit0 inverted on odd vectors only -> err_count=5, first_err_vec=1. Repeat with ERR_W=2 -> err_count=3 (saturated).
- Masking: same fault as the persistent case but ref_valid_i[2]=0 -> err_count=0, pass=1.
- Reset mid-run: rst_n pulsed low during vector 4 -> outputs return to 0 and state IDLE. A start during busy earlier in the run has no effect. A new start after reset -> stim_o=9'h003 again.
